writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
// PURPOSE
//   Write-side master for the 32x32 register file: owns its single write port
//   (RDaddr/RDdata/regwrite). Merges in-order pipeline WB writes with results
//   from a long-latency unit (mul/div, slow memory) buffered in a small FIFO.
//   Reports pending queued writes per read address so the hazard unit can stall or forward.
// PARAMETERS
//   DEPTH  4   queue entries (power of two, >=2)
//   AW     5   register address width
//   DW     32  register data width
// PORTS
//   clk_i        in   1    clock, all state on rising edge
//   rst_i        in   1    asynchronous reset, active-high
//   pipe_we_i    in   1    pipeline WB write request (no handshake, always served)
//   pipe_addr_i  in   AW   pipeline WB destination register
//   pipe_data_i  in   DW   pipeline WB data
//   lu_valid_i   in   1    long-latency result valid
//   lu_addr_i    in   AW   long-latency destination register
//   lu_data_i    in   DW   long-latency result data
//   lu_ready_o   out  1    queue can accept; transfer = lu_valid_i & lu_ready_o
//   RDaddr_o     out  AW   register-file write address (registered)
//   RDdata_o     out  DW   register-file write data (registered)
//   regwrite_o   out  1    register-file write enable (registered)
//   RSaddr_i     in   AW   read address A for pending lookup
//   RTaddr_i     in   AW   read address B for pending lookup
//   RSpend_o     out  1    live queued write targets RSaddr_i
//   RTpend_o     out  1    live queued write targets RTaddr_i
//   RSfwd_o      out  DW   data of youngest live entry matching RSaddr_i
//   RTfwd_o      out  DW   data of youngest live entry matching RTaddr_i
//   count_o      out  log2(DEPTH)+1  occupied slots, live or squashed
// BEHAVIOUR
//   - Reset: queue empty, all entries dead, count_o=0, regwrite_o=0, RDaddr_o=0,
//     RDdata_o=0, lu_ready_o=1.
//   - lu_ready_o = (count_o < DEPTH); combinational from count only, no same-cycle
//     pass-through when full even if a pop occurs.
//   - Accepted lu write with lu_addr_i==0: dropped, not enqueued, ready unaffected.
//   - Issue arbiter, evaluated each cycle, result registered to RD*/regwrite_o:
//     1) pipe_we_i & pipe_addr_i!=0: issue pipeline write; queue head holds.
//     2) else head present & live: issue head, pop.
//     3) else head present & dead (squashed): pop, regwrite_o=0.
//     4) else regwrite_o=0; RDaddr_o/RDdata_o hold previous values.
//   - pipe_we_i with pipe_addr_i==0: treated as no request; queue may issue.
//   - Latency: pipeline write reaches regwrite_o 1 cycle after request; an lu
//     write accepted into an empty queue issues no earlier than 2 cycles after.
//   - WAW squash: a pipeline write issued to register R marks every queued entry
//     with address R dead, including an lu entry enqueued in the same cycle.
//     Dead entries still occupy slots until popped.
//   - Push and pop in same cycle: count unchanged; pointers wrap modulo DEPTH.
//   - Pending lookup is combinational over live queue entries only (output stage
//     excluded; the register file bypasses its own write). Address 0 never pends.
//   - Reset mid-operation discards all queued entries; nothing is written.
// CONFIGURATION
//   WBQ_FWD_EN defined: RSfwd_o/RTfwd_o return youngest live matching entry data
//     (0 when no match); youngest-first priority mux over DEPTH entries.
//   WBQ_FWD_EN undefined: RSfwd_o/RTfwd_o tied to 0; RS/RTpend_o unchanged.
// TESTING
//   - Reset then idle -> regwrite_o=0, lu_ready_o=1, count_o=0, pend outputs 0.
//   - lu write R5=0xDEAD, no pipe traffic -> RSpend_o=1 for RSaddr_i=5 and, with
//     WBQ_FWD_EN, RSfwd_o=0xDEAD; regwrite_o=1 addr 5 two cycles after accept.
//   - Fill 4 lu writes (R1..R4) while pipe_we_i held high -> lu_ready_o=0 at
//     count 4; pipe writes issue every cycle; queue drains R1..R4 in order after.
//   - Queue holds R7=0x11; pipe writes R7=0x22 -> regwrite_o R7=0x22, R7 entry
//     dead, later pops with no write; RSpend_o for R7 drops to 0.
//   - Queue holds R3=0xA then R3=0xB -> RSfwd_o=0xB (youngest); lu write R0 and
//     pipe write R0 -> no enqueue, no regwrite_o.
//   - Reset asserted with 3 entries queued -> count_o=0 immediately, no writes follow.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue: register-file write master merging pipeline WB writes with a queued long-latency stream.
// Optional macro WBQ_FWD_EN enables youngest-match data forwarding on RSfwd_o/RTfwd_o.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pipe_we_i,
    input  logic [AW-1:0] pipe_addr_i,
    input  logic [DW-1:0] pipe_data_i,
    input  logic          lu_valid_i,
    input  logic [AW-1:0] lu_addr_i,
    input  logic [DW-1:0] lu_data_i,
    output logic          lu_ready_o,
    output logic [AW-1:0] RDaddr_o,
    output logic [DW-1:0] RDdata_o,
    output logic          regwrite_o,
    input  logic [AW-1:0] RSaddr_i,
    input  logic [AW-1:0] RTaddr_i,
    output logic          RSpend_o,
    output logic          RTpend_o,
    output logic [DW-1:0] RSfwd_o,
    output logic [DW-1:0] RTfwd_o,
    output logic [PW:0]   count_o
);
    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic          r_live [DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [PW:0]   r_count;
    logic          w_pipe, w_push, w_pop, w_issue_q;
    logic [PW-1:0] w_idx;

    assign count_o    = r_count;
    assign lu_ready_o = r_count < (PW+1)'(DEPTH);
    assign w_pipe     = pipe_we_i & (pipe_addr_i != '0);
    assign w_push     = lu_valid_i & lu_ready_o & (lu_addr_i != '0);
    assign w_pop      = !w_pipe & (r_count != '0);
    assign w_issue_q  = w_pop & r_live[r_head];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            regwrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_live[i] <= 1'b0;
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_count    <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
            regwrite_o <= w_pipe | w_issue_q;
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop) r_head <= r_head + PW'(1);
            if (w_pipe) begin
                RDaddr_o <= pipe_addr_i;
                RDdata_o <= pipe_data_i;
            end else if (w_issue_q) begin
                RDaddr_o <= r_addr[r_head];
                RDdata_o <= r_data[r_head];
            end
            // live implies occupied: popped slots are cleared so lookups need no range check
            for (int i = 0; i < DEPTH; i++)
                if ((w_pipe && r_addr[i] == pipe_addr_i) || (w_pop && PW'(i) == r_head))
                    r_live[i] <= 1'b0;
            if (w_push) begin
                r_addr[r_tail] <= lu_addr_i;
                r_data[r_tail] <= lu_data_i;
                r_live[r_tail] <= !(w_pipe && lu_addr_i == pipe_addr_i);
            end
        end
    end

    // scan oldest to youngest so the last match wins
    always_comb begin
        RSpend_o = 1'b0;
        RTpend_o = 1'b0;
        RSfwd_o  = '0;
        RTfwd_o  = '0;
        w_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (r_live[w_idx] && r_addr[w_idx] == RSaddr_i) begin
                RSpend_o = 1'b1;
`ifdef WBQ_FWD_EN
                RSfwd_o  = r_data[w_idx];
`endif
            end
            if (r_live[w_idx] && r_addr[w_idx] == RTaddr_i) begin
                RTpend_o = 1'b1;
`ifdef WBQ_FWD_EN
                RTfwd_o  = r_data[w_idx];
`endif
            end
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed vector bench for writeback_queue.
module tb_writeback_queue;
    logic        clk = 1'b0, rst = 1'b1;
    logic        pipe_we, lu_valid, lu_ready, regwrite, rs_pend, rt_pend;
    logic [4:0]  pipe_addr, lu_addr, rd_addr, rs_addr, rt_addr;
    logic [31:0] pipe_data, lu_data, rd_data, rs_fwd, rt_fwd;
    logic [2:0]  count;
    int checks = 0, errors = 0;

    writeback_queue dut (
        .clk_i(clk), .rst_i(rst),
        .pipe_we_i(pipe_we), .pipe_addr_i(pipe_addr), .pipe_data_i(pipe_data),
        .lu_valid_i(lu_valid), .lu_addr_i(lu_addr), .lu_data_i(lu_data), .lu_ready_o(lu_ready),
        .RDaddr_o(rd_addr), .RDdata_o(rd_data), .regwrite_o(regwrite),
        .RSaddr_i(rs_addr), .RTaddr_i(rt_addr), .RSpend_o(rs_pend), .RTpend_o(rt_pend),
        .RSfwd_o(rs_fwd), .RTfwd_o(rt_fwd), .count_o(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pwe; logic [4:0] pa; logic [31:0] pd;
        logic lv;  logic [4:0] la; logic [31:0] ld;
        logic [4:0] rs, rt;
        logic rw; logic [4:0] rda; logic [31:0] rdd; logic [2:0] cnt;
        logic rdy, rsp, rtp; logic [31:0] rsf;
    } vec_t;
    vec_t v [22];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_we = pwe; pipe_addr = pa; pipe_data = pd;
        lu_valid = lv; lu_addr = la; lu_data = ld;
    endtask

    initial begin
        logic [31:0] exp_fwd;
        //        pwe  pa     pd        lv   la     ld         rs     rt     rw   rda    rdd       cnt   rdy  rsp  rtp  rsf
        v[0]  = '{1'b0,5'd0, 32'h0,   1'b1,5'd5, 32'hDEAD, 5'd5, 5'd6, 1'b0,5'd0, 32'h0,   3'd1,1'b1,1'b1,1'b0,32'hDEAD};
        v[1]  = '{1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,    5'd5, 5'd6, 1'b1,5'd5, 32'hDEAD,3'd0,1'b1,1'b0,1'b0,32'h0};
        v[2]  = '{1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,    5'd5, 5'd6, 1'b0,5'd5, 32'hDEAD,3'd0,1'b1,1'b0,1'b0,32'h0};
        v[3]  = '{1'b1,5'd10,32'h100, 1'b1,5'd1, 32'h1,    5'd1, 5'd4, 1'b1,5'd10,32'h100, 3'd1,1'b1,1'b1,1'b0,32'h1};
        v[4]  = '{1'b1,5'd11,32'h101, 1'b1,5'd2, 32'h2,    5'd1, 5'd4, 1'b1,5'd11,32'h101, 3'd2,1'b1,1'b1,1'b0,32'h1};
        v[5]  = '{1'b1,5'd12,32'h102, 1'b1,5'd3, 32'h3,    5'd1, 5'd4, 1'b1,5'd12,32'h102, 3'd3,1'b1,1'b1,1'b0,32'h1};
        v[6]  = '{1'b1,5'd13,32'h103, 1'b1,5'd4, 32'h4,    5'd1, 5'd4, 1'b1,5'd13,32'h103, 3'd4,1'b0,1'b1,1'b1,32'h1};
        v[7]  = '{1'b1,5'd14,32'h104, 1'b1,5'd9, 32'h9,    5'd1, 5'd4, 1'b1,5'd14,32'h104, 3'd4,1'b0,1'b1,1'b1,32'h1};
        v[8]  = '{1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,    5'd1, 5'd4, 1'b1,5'd1, 32'h1,   3'd3,1'b1,1'b0,1'b1,32'h0};
        v[9]  = '{1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,    5'd1, 5'd4, 1'b1,5'd2, 32'h2,   3'd2,1'b1,1'b0,1'b1,32'h0};
        v[10] = '{1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,    5'd1, 5'd4, 1'b1,5'd3, 32'h3,   3'd1,1'b1,1'b0,1'b1,32'h0};
        v[11] = '{1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,    5'd1, 5'd4, 1'b1,5'd4, 32'h4,   3'd0,1'b1,1'b0,1'b0,32'h0};
        v[12] = '{1'b0,5'd0, 32'h0,   1'b1,5'd7, 32'h11,   5'd7, 5'd0, 1'b0,5'd4, 32'h4,   3'd1,1'b1,1'b1,1'b0,32'h11};
        v[13] = '{1'b1,5'd7, 32'h22,  1'b0,5'd0, 32'h0,    5'd7, 5'd0, 1'b1,5'd7, 32'h22,  3'd1,1'b1,1'b0,1'b0,32'h0};
        v[14] = '{1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,    5'd7, 5'd0, 1'b0,5'd7, 32'h22,  3'd0,1'b1,1'b0,1'b0,32'h0};
        v[15] = '{1'b0,5'd0, 32'h0,   1'b1,5'd3, 32'hA,    5'd3, 5'd3, 1'b0,5'd7, 32'h22,  3'd1,1'b1,1'b1,1'b1,32'hA};
        v[16] = '{1'b1,5'd20,32'h20,  1'b1,5'd3, 32'hB,    5'd3, 5'd3, 1'b1,5'd20,32'h20,  3'd2,1'b1,1'b1,1'b1,32'hB};
        v[17] = '{1'b1,5'd0, 32'h55,  1'b1,5'd0, 32'h77,   5'd3, 5'd3, 1'b1,5'd3, 32'hA,   3'd1,1'b1,1'b1,1'b1,32'hB};
        v[18] = '{1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,    5'd3, 5'd3, 1'b1,5'd3, 32'hB,   3'd0,1'b1,1'b0,1'b0,32'h0};
        v[19] = '{1'b1,5'd0, 32'h55,  1'b1,5'd0, 32'h77,   5'd3, 5'd3, 1'b0,5'd3, 32'hB,   3'd0,1'b1,1'b0,1'b0,32'h0};
        v[20] = '{1'b1,5'd8, 32'h88,  1'b1,5'd8, 32'h99,   5'd8, 5'd8, 1'b1,5'd8, 32'h88,  3'd1,1'b1,1'b0,1'b0,32'h0};
        v[21] = '{1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,    5'd8, 5'd8, 1'b0,5'd8, 32'h88,  3'd0,1'b1,1'b0,1'b0,32'h0};

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rs_addr = 5'd5; rt_addr = 5'd6;
        repeat (2) @(posedge clk);
        #1;
        check("rst_regwrite", -1, 32'(regwrite), 32'd0);
        check("rst_ready", -1, 32'(lu_ready), 32'd1);
        check("rst_count", -1, 32'(count), 32'd0);
        check("rst_rspend", -1, 32'(rs_pend), 32'd0);
        check("rst_rtpend", -1, 32'(rt_pend), 32'd0);
        check("rst_rdaddr", -1, 32'(rd_addr), 32'd0);
        check("rst_rddata", -1, rd_data, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(v[i].pwe, v[i].pa, v[i].pd, v[i].lv, v[i].la, v[i].ld);
            rs_addr = v[i].rs; rt_addr = v[i].rt;
            @(posedge clk);
            #1;
`ifdef WBQ_FWD_EN
            exp_fwd = v[i].rsf;
`else
            exp_fwd = 32'h0;
`endif
            check("regwrite", i, 32'(regwrite), 32'(v[i].rw));
            check("rdaddr", i, 32'(rd_addr), 32'(v[i].rda));
            check("rddata", i, rd_data, v[i].rdd);
            check("count", i, 32'(count), 32'(v[i].cnt));
            check("ready", i, 32'(lu_ready), 32'(v[i].rdy));
            check("rspend", i, 32'(rs_pend), 32'(v[i].rsp));
            check("rtpend", i, 32'(rt_pend), 32'(v[i].rtp));
            check("rsfwd", i, rs_fwd, exp_fwd);
        end

        // queue three entries behind a busy pipeline, then reset mid-operation
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(1'b1, 5'd15, 32'(k), 1'b1, 5'(k), 32'(k));
            @(posedge clk);
            #1;
            check("mid_count", 100 + k, 32'(count), 32'(k));
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        #1;
        check("async_rst_count", 200, 32'(count), 32'd0);
        check("async_rst_regwrite", 200, 32'(regwrite), 32'd0);
        check("async_rst_ready", 200, 32'(lu_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_regwrite", 300 + k, 32'(regwrite), 32'd0);
            check("post_rst_count", 300 + k, 32'(count), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
